// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - run-control sequencer for the ADC trigger/burst capture datapath
module adc_capture_sequencer #(
    parameter int CLEAR_W = 8,
    parameter int TMO_W   = 32
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [15:0]        cfg_num_bursts,
    input  logic [CLEAR_W-1:0] cfg_clear_cycles,
    input  logic [TMO_W-1:0]   cfg_timeout,
    input  logic               adc_tvalid,
    input  logic               adc_tlast,
    input  logic               wr_almost_full,
    output logic               nreset_trigger,
    output logic               nreset_max_sum,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic               aborted,
    output logic [15:0]        bursts_done,
    output logic [31:0]        words_done,
    output logic [2:0]         state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d, cnt_next;
    logic [15:0]        nb_q, nb_d;
    logic [CLEAR_W-1:0] clr_q, clr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               done_q, done_d, to_q, to_d, ab_q, ab_d;
    logic [15:0]        bursts_q, bursts_d, bursts_inc;
    logic [31:0]        words_q, words_d;
    logic               nrt_q, nrt_d, nms_q, nms_d, busy_q, busy_d;
    logic               burst_end;

    // Next-state, counters and run-status; outputs are decoded from the next state so they are registered
    always_comb begin
        state_d    = state_q;
        nb_d       = nb_q;
        clr_d      = clr_q;
        tmo_d      = tmo_q;
        done_d     = done_q;
        to_d       = to_q;
        ab_d       = ab_q;
        bursts_d   = bursts_q;
        words_d    = words_q;
        burst_end  = 1'b0;
        cnt_next   = cnt_q + 1'b1;
        bursts_inc = (bursts_q == 16'hFFFF) ? bursts_q : bursts_q + 16'd1;

        // Every word seen after arming is counted, including strays after a stop or pause decision
        if (state_q != ST_IDLE && state_q != ST_CLEAR && adc_tvalid && words_q != 32'hFFFF_FFFF) begin
            words_d = words_q + 32'd1;
        end

        if (state_q == ST_IDLE) begin
            if (cfg_start && !cfg_abort) begin
                nb_d     = cfg_num_bursts;
                clr_d    = cfg_clear_cycles;
                tmo_d    = cfg_timeout;
                bursts_d = 16'd0;
                words_d  = 32'd0;
                done_d   = 1'b0;
                to_d     = 1'b0;
                ab_d     = 1'b0;
                state_d  = ST_CLEAR;
            end
        end else if (cfg_abort) begin
            // A burst cut short by abort is never counted, even if its tlast arrives this cycle
            ab_d    = 1'b1;
            state_d = ST_DRAIN;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == TMO_W'(clr_q)) state_d = ST_ARMED;
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (adc_tvalid && adc_tlast) begin
                        burst_end = 1'b1;
                        bursts_d  = bursts_inc;
                        if (nb_q != 16'd0 && bursts_inc == nb_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DRAIN;
                        end else if (wr_almost_full) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else if (adc_tvalid) begin
                        state_d = ST_CAPTURE;
                    end else if (state_q == ST_ARMED && tmo_q != '0 && cnt_next == tmo_q) begin
                        to_d    = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_PAUSE: begin
                    if (!wr_almost_full) state_d = ST_ARMED;
                end
                ST_DRAIN: begin
                    if (cnt_q == TMO_W'(1)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Phase counter restarts on every state change and on every burst end (ARMED re-entry)
        cnt_d  = (state_d != state_q || burst_end) ? '0 : cnt_next;
        nrt_d  = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        nms_d  = (state_d != ST_CLEAR);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset holds the ADC fully cleared
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            nb_q     <= 16'd0;
            clr_q    <= '0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            ab_q     <= 1'b0;
            bursts_q <= 16'd0;
            words_q  <= 32'd0;
            nrt_q    <= 1'b0;
            nms_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nb_q     <= nb_d;
            clr_q    <= clr_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            to_q     <= to_d;
            ab_q     <= ab_d;
            bursts_q <= bursts_d;
            words_q  <= words_d;
            nrt_q    <= nrt_d;
            nms_q    <= nms_d;
            busy_q   <= busy_d;
        end
    end

    assign state          = state_q;
    assign nreset_trigger = nrt_q;
    assign nreset_max_sum = nms_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timed_out      = to_q;
    assign aborted        = ab_q;
    assign bursts_done    = bursts_q;
    assign words_done     = words_q;

endmodule
